itr_ctrl: RTL and testbench



---
 rtl/itr_ctrl_if.sv | 31 +++
 rtl/itr_ctrl.sv | 135 +++++++++++++
 tb/tb_itr_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/itr_ctrl_if.sv
// Processor I/O port bus and interrupt lines seen by the interrupt controller.
interface itr_ctrl_if #(
  parameter int unsigned NSRC   = 4,
  parameter int unsigned NBDATA = 23,
  parameter int unsigned NUIOIN = 2,
  parameter int unsigned NUIOOU = 2
);
  localparam int unsigned AIW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
  localparam int unsigned AOW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

  logic [NSRC-1:0]   src;
  logic [AIW-1:0]    addr_in;
  logic              req_in;
  logic [AOW-1:0]    addr_out;
  logic              out_en;
  logic [NBDATA-1:0] io_out;
  logic [NBDATA-1:0] vec_out;
  logic              itr;
  logic              busy;
  logic [NSRC-1:0]   pend;

  modport master (
    output src, addr_in, req_in, addr_out, out_en, io_out,
    input  vec_out, itr, busy, pend
  );

  modport slave (
    input  src, addr_in, req_in, addr_out, out_en, io_out,
    output vec_out, itr, busy, pend
  );
endinterface

// File: rtl/itr_ctrl.sv
// Prioritised interrupt controller: edge-detects source requests, masks them, raises itr for
// the lowest-index eligible source and runs the vector-read / end-of-interrupt handshake.
module itr_ctrl #(
  parameter int unsigned NSRC   = 4,
  parameter int unsigned NBDATA = 23,
  parameter int unsigned NUIOIN = 2,
  parameter int unsigned NUIOOU = 2,
  parameter int unsigned VECADR = 0,
  parameter int unsigned MSKADR = 0,
  parameter int unsigned EOIADR = 1,
  parameter int unsigned MSKRST = 0,
  parameter int unsigned TMOUT  = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  itr_ctrl_if.slave   bus_io
);
  localparam int unsigned AIW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
  localparam int unsigned AOW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;
  localparam int unsigned SW  = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int unsigned CW  = (TMOUT > 0) ? $clog2(TMOUT + 1) : 1;
  // Counter value on the last REQ cycle before the request is withdrawn.
  localparam logic [CW-1:0] TmoLast = CW'((TMOUT == 0) ? 0 : TMOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StServ} state_e;

  state_e          state_q;
  logic [SW-1:0]   sel_q;
  logic            itr_q;
  logic [CW-1:0]   cnt_q;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, mask_d;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] pend_clr;
  logic [SW-1:0]   first_idx;
  logic            vec_rd;
  logic            msk_wr;
  logic            eoi_wr;
  logic            sel_masked;
  logic            unused_io;

  assign unused_io = ^bus_io.io_out;

  // Decode bus strobes, detect edges and pick the highest-priority eligible source.
  always_comb begin
    rise       = bus_io.src & ~src_q;
    elig       = pend_q & mask_q;
    vec_rd     = bus_io.req_in && (bus_io.addr_in == AIW'(VECADR));
    msk_wr     = bus_io.out_en && (bus_io.addr_out == AOW'(MSKADR));
    eoi_wr     = bus_io.out_en && (bus_io.addr_out == AOW'(EOIADR));
    sel_masked = msk_wr && !bus_io.io_out[sel_q];
    first_idx  = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) first_idx = SW'(i);
    end
    pend_clr = '0;
    if (state_q == StReq && vec_rd) pend_clr = NSRC'(1) << sel_q;
  end

  // Pending and mask next state; a new edge wins over the vector-read clear.
  always_comb begin
    pend_d = (pend_q & ~pend_clr) | rise;
    mask_d = msk_wr ? bus_io.io_out[NSRC-1:0] : mask_q;
  end

  // Edge-detect history, pending and mask registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q  <= '0;
      pend_q <= '0;
      mask_q <= NSRC'(MSKRST);
    end else begin
      src_q  <= bus_io.src;
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  end

  // Request sequencing FSM with registered itr.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      sel_q   <= '0;
      itr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (|elig) begin
            sel_q   <= first_idx;
            state_q <= StReq;
            itr_q   <= 1'b1;
            cnt_q   <= '0;
          end
        end
        StReq: begin
          if (vec_rd) begin
            // Vector read takes priority over a simultaneous mask write.
            state_q <= StServ;
            itr_q   <= 1'b0;
            cnt_q   <= '0;
          end else if (sel_masked) begin
            state_q <= StIdle;
            itr_q   <= 1'b0;
            cnt_q   <= '0;
          end else if (TMOUT != 0 && cnt_q == TmoLast) begin
            state_q <= StIdle;
            itr_q   <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StServ: begin
          if (eoi_wr) state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          itr_q   <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus_io.itr     = itr_q;
  assign bus_io.busy    = (state_q != StIdle);
  assign bus_io.pend    = pend_q;
  // Vector only while a request is outstanding; otherwise the "no source" code NSRC.
  assign bus_io.vec_out = (state_q == StReq && bus_io.addr_in == AIW'(VECADR)) ?
                          NBDATA'(sel_q) : NBDATA'(NSRC);
endmodule

// File: tb/tb_itr_ctrl.sv
// Directed and randomized bench for itr_ctrl against a behavioural model of the controller.
module tb_itr_ctrl;
  localparam int unsigned NSRC   = 4;
  localparam int unsigned NBDATA = 23;
  localparam int unsigned TMOUT  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  itr_ctrl_if #(.NSRC(NSRC), .NBDATA(NBDATA), .NUIOIN(2), .NUIOOU(2)) bus ();

  itr_ctrl #(
    .NSRC(NSRC), .NBDATA(NBDATA), .NUIOIN(2), .NUIOOU(2),
    .VECADR(0), .MSKADR(0), .EOIADR(1), .MSKRST(0), .TMOUT(TMOUT)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus)
  );

  int checks = 0;
  int failures = 0;

  // Model: phase 0 = waiting, 1 = request raised, 2 = being serviced.
  int m_pend, m_mask, m_srcq, m_phase, m_sel, m_age;
  logic [NBDATA-1:0] last_vec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_pend = 0; m_mask = 0; m_srcq = 0; m_phase = 0; m_sel = 0; m_age = 0;
  endfunction

  // Index of the lowest set bit, via isolating it arithmetically.
  function automatic int lowest(input int v);
    int iso;
    iso = v & (~v + 1);
    return $clog2(iso);
  endfunction

  function automatic void model_advance(input int s, input int ai, input int ri,
                                        input int ao, input int oe, input int d);
    int  rise;
    bit  rd, mw, eo;
    rise = s & ~m_srcq & 15;
    rd = (ri != 0) && (ai == 0);
    mw = (oe != 0) && (ao == 0);
    eo = (oe != 0) && (ao == 1);
    case (m_phase)
      0: if ((m_pend & m_mask) != 0) begin
        m_sel = lowest(m_pend & m_mask);
        m_phase = 1;
        m_age = 0;
      end
      1: begin
        m_age++;
        if (rd) begin
          m_pend = m_pend & ~(1 << m_sel);
          m_phase = 2;
        end else if (mw && ((d >> m_sel) & 1) == 0) m_phase = 0;
        else if (m_age == TMOUT) m_phase = 0;
      end
      default: if (eo) m_phase = 0;
    endcase
    m_pend = m_pend | rise;
    if (mw) m_mask = d & 15;
    m_srcq = s & 15;
  endfunction

  // One clock: drive, check at the falling edge, advance the model at the rising edge.
  task automatic step(input int s, input int ai, input int ri, input int ao, input int oe,
                      input int d);
    bus.src = s[3:0];
    bus.addr_in = ai[0];
    bus.req_in = ri[0];
    bus.addr_out = ao[0];
    bus.out_en = oe[0];
    bus.io_out = d[NBDATA-1:0];
    @(negedge clk);
    last_vec = bus.vec_out;
    chk("itr", bus.itr, m_phase == 1);
    chk("busy", bus.busy, m_phase != 0);
    chk("pend", bus.pend, m_pend);
    chk("vec_out", bus.vec_out, (m_phase == 1 && ai == 0) ? m_sel : NSRC);
    @(posedge clk);
    model_advance(s, ai, ri, ao, oe, d);
    #1;
  endtask

  task automatic wait_itr();
    for (int k = 0; k < 10; k++) begin
      if (bus.itr === 1'b1) break;
      step(0, 0, 0, 0, 0, 0);
    end
    chk("wait_itr", bus.itr, 1);
  endtask

  task automatic serve(output int v);
    wait_itr();
    step(0, 0, 1, 0, 0, 0);
    v = int'(last_vec);
    step(0, 0, 0, 1, 1, 0);
  endtask

  initial begin
    int v;
    int cur;
    bus.src = 4'b0101; bus.addr_in = 0; bus.req_in = 0;
    bus.addr_out = 0; bus.out_en = 0; bus.io_out = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_itr", bus.itr, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pend", bus.pend, 0);
    model_reset();
    rst_n = 1'b1;

    // Held-high lines register as edges once reset is released.
    step(5, 0, 0, 0, 0, 0);
    chk("pend_after_rst", bus.pend, 4'b0101);
    step(5, 0, 0, 0, 0, 0);
    chk("vec_none", last_vec, NSRC);
    chk("itr_masked", bus.itr, 0);

    // Enable everything and drain the reset-time requests.
    step(0, 0, 0, 0, 1, 'hF);
    serve(v); chk("drain_first", v, 0);
    serve(v); chk("drain_second", v, 2);

    // Single pulse on source 2.
    step(4, 0, 0, 0, 0, 0);
    chk("itr_lat1", bus.itr, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("itr_lat2", bus.itr, 1);
    step(0, 0, 1, 0, 0, 0);
    chk("vec2", last_vec, 2);
    chk("pend2_clr", bus.pend[2], 0);
    chk("itr_drop", bus.itr, 0);
    step(0, 0, 0, 1, 1, 0);
    chk("busy_eoi", bus.busy, 0);

    // Simultaneous edges on 3 and 1.
    step(10, 0, 0, 0, 0, 0);
    serve(v); chk("prio_first", v, 1);
    serve(v); chk("prio_second", v, 3);

    // New edge while being serviced waits for EOI.
    step(4, 0, 0, 0, 0, 0);
    wait_itr();
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    chk("serv_itr_low", bus.itr, 0);
    step(0, 0, 0, 1, 1, 0);
    serve(v); chk("serv_then_vec0", v, 0);

    // Timeout: request withdrawn after TMOUT cycles, then re-raised.
    step(2, 0, 0, 0, 0, 0);
    wait_itr();
    repeat (3) step(0, 0, 0, 0, 0, 0);
    chk("tmo_still_high", bus.itr, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("tmo_drop", bus.itr, 0);
    chk("tmo_pend_kept", bus.pend[1], 1);
    step(0, 0, 0, 0, 0, 0);
    chk("tmo_rearm", bus.itr, 1);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);

    // Masking the selected source withdraws the request.
    step(4, 0, 0, 0, 0, 0);
    wait_itr();
    step(0, 0, 0, 0, 1, 3);
    chk("mask_itr", bus.itr, 0);
    chk("mask_pend", bus.pend[2], 1);
    chk("mask_busy", bus.busy, 0);
    step(0, 0, 0, 0, 1, 'hF);
    wait_itr();

    // Asynchronous reset in the middle of a request.
    rst_n = 1'b0;
    #1;
    chk("arst_itr", bus.itr, 0);
    chk("arst_pend", bus.pend, 0);
    chk("arst_busy", bus.busy, 0);
    model_reset();
    #1 rst_n = 1'b1;

    // Randomized traffic.
    cur = 0;
    for (int n = 0; n < 500; n++) begin
      int ri, ai, oe, ao, d;
      if ($urandom_range(0, 2) == 0) cur = cur ^ int'($urandom_range(0, 15));
      ri = ($urandom_range(0, 3) == 0) ? 1 : 0;
      ai = int'($urandom_range(0, 1));
      oe = ($urandom_range(0, 4) == 0) ? 1 : 0;
      ao = int'($urandom_range(0, 1));
      d  = int'($urandom_range(0, 32'h7FFFFF));
      step(cur, ai, ri, ao, oe, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
